pipeline_hazard_ctrl: RTL and testbench

Hazard and stall sequencer for the five-stage RISC-V pipeline. It drives the stage-register stall and flush controls (StallF, StallD, FlushD, FlushE, plus StallE, StallM, FlushW) and the E-stage forwarding selects. It also runs the data-memory wait-state handshake, so a multi-cycle memory access freezes the pipeline cleanly. Combinational hazard decode sits beside a registered memory-wait FSM and a timeout watchdog.

---
 rtl/pipeline_hazard_ctrl.sv | 133 +++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/stall sequencer for the five-stage pipeline: forwarding, load-use and branch control,
// data-memory wait FSM with timeout watchdog. Optional counters: PIPELINE_HAZARD_PERF_EN.
module pipeline_hazard_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       Rs1D,
    input  logic [4:0]       Rs2D,
    input  logic [4:0]       Rs1E,
    input  logic [4:0]       Rs2E,
    input  logic [4:0]       RdE,
    input  logic [4:0]       RdM,
    input  logic [4:0]       RdW,
    input  logic             RegWriteM,
    input  logic             RegWriteW,
    input  logic             LoadE,
    input  logic             PCSrcE,
    input  logic             MemAccessM,
    input  logic             MemReadyM,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             StallM,
    output logic             FlushD,
    output logic             FlushE,
    output logic             FlushW,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic             MemReqM,
    output logic             MemErr,
    output logic [CNT_W-1:0] StallCnt,
    output logic [CNT_W-1:0] FlushCnt
);

    typedef enum logic {M_IDLE, M_WAIT} mstate_t;

    mstate_t     state;
    logic [15:0] wd;
    logic        memstall;
    logic        lwstall;

    function automatic logic [1:0] fwd_sel(input logic [4:0] rs);
        if (RegWriteM && RdM != 5'd0 && RdM == rs)
            return 2'b10;
        else if (RegWriteW && RdW != 5'd0 && RdW == rs)
            return 2'b01;
        else
            return 2'b00;
    endfunction

    assign memstall = MemAccessM & ~MemReadyM;
    assign lwstall  = LoadE & (RdE != 5'd0) & ((Rs1D == RdE) | (Rs2D == RdE));

    always_comb begin
        StallF    = 1'b0;
        StallD    = 1'b0;
        StallE    = 1'b0;
        StallM    = 1'b0;
        FlushD    = 1'b0;
        FlushE    = 1'b0;
        FlushW    = 1'b0;
        MemReqM   = 1'b0;
        ForwardAE = 2'b00;
        ForwardBE = 2'b00;
        if (rst) begin
            FlushD = 1'b1;
            FlushE = 1'b1;
            FlushW = 1'b1;
        end else begin
            MemReqM   = MemAccessM;
            ForwardAE = fwd_sel(Rs1E);
            ForwardBE = fwd_sel(Rs2E);
            // A memory wait freezes D and E, so any pending branch/load-use flush is deferred
            if (memstall) begin
                StallF = 1'b1;
                StallD = 1'b1;
                StallE = 1'b1;
                StallM = 1'b1;
                FlushW = 1'b1;
            end else begin
                StallF = lwstall;
                StallD = lwstall;
                FlushE = lwstall | PCSrcE;
                FlushD = PCSrcE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= M_IDLE;
            wd     <= '0;
            MemErr <= 1'b0;
        end else begin
            case (state)
                M_IDLE: begin
                    wd <= '0;
                    if (memstall)
                        state <= M_WAIT;
                end
                M_WAIT: begin
                    if (wd < 16'(MEM_TIMEOUT))
                        wd <= wd + 16'd1;
                    if (({1'b0, wd} + 17'd1) >= 17'(MEM_TIMEOUT))
                        MemErr <= 1'b1;
                    if (MemReadyM)
                        state <= M_IDLE;
                end
                default: state <= M_IDLE;
            endcase
        end
    end

`ifdef PIPELINE_HAZARD_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            StallCnt <= '0;
            FlushCnt <= '0;
        end else begin
            if (StallF | StallD | StallE | StallM)
                StallCnt <= StallCnt + CNT_W'(1);
            if (FlushD | FlushE)
                FlushCnt <= FlushCnt + CNT_W'(1);
        end
    end
`else
    assign StallCnt = '0;
    assign FlushCnt = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: directed test-plan sequences followed by random traffic.
module tb_pipeline_hazard_ctrl;

    localparam int unsigned T = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic        RegWriteM, RegWriteW, LoadE, PCSrcE, MemAccessM, MemReadyM;
    logic        StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW;
    logic [1:0]  ForwardAE, ForwardBE;
    logic        MemReqM, MemErr;
    logic [31:0] StallCnt, FlushCnt;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.MEM_TIMEOUT(T), .CNT_W(32)) dut (
        .clk(clk), .rst(rst),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .RdM(RdM), .RdW(RdW),
        .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .LoadE(LoadE), .PCSrcE(PCSrcE),
        .MemAccessM(MemAccessM), .MemReadyM(MemReadyM),
        .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
        .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .MemReqM(MemReqM), .MemErr(MemErr), .StallCnt(StallCnt), .FlushCnt(FlushCnt)
    );

    typedef struct {
        bit       rst;
        bit [4:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
        bit       rwm, rww, loade, pcsrc, macc, mrdy;
    } stim_t;

    typedef struct {
        bit [1:0]  fa, fb;
        bit        sf, sd, se, sm, fd, fe, fw, req, err;
        bit [31:0] sc, fc;
    } exp_t;

    exp_t        q[$];
    exp_t        m_e;
    int unsigned checks = 0;
    int unsigned errors = 0;

    // reference model state: "inside a memory wait", cycles spent waiting, sticky error, counters
    bit          m_wait = 1'b0;
    int unsigned m_cnt  = 0;
    bit          m_err  = 1'b0;
    bit [31:0]   m_sc   = 0;
    bit [31:0]   m_fc   = 0;
    stim_t       prev_s;
    exp_t        prev_e;

    function automatic stim_t idle();
        stim_t s;
        s = '{default: '0};
        return s;
    endfunction

    function automatic bit [1:0] fsel(stim_t s, bit [4:0] rs);
        if (s.rwm && s.rdm != 0 && s.rdm == rs) return 2'b10;
        if (s.rww && s.rdw != 0 && s.rdw == rs) return 2'b01;
        return 2'b00;
    endfunction

    function automatic exp_t predict(stim_t s);
        exp_t e;
        bit mem, lw;
        e = '{default: '0};
        e.err = m_err;
`ifdef PIPELINE_HAZARD_PERF_EN
        e.sc = m_sc;
        e.fc = m_fc;
`endif
        if (s.rst) begin
            e.fd = 1; e.fe = 1; e.fw = 1;
            return e;
        end
        mem   = s.macc && !s.mrdy;
        lw    = s.loade && s.rde != 0 && (s.rs1d == s.rde || s.rs2d == s.rde);
        e.fa  = fsel(s, s.rs1e);
        e.fb  = fsel(s, s.rs2e);
        e.req = s.macc;
        if (mem) begin
            e.sf = 1; e.sd = 1; e.se = 1; e.sm = 1; e.fw = 1;
        end else begin
            e.sf = lw; e.sd = lw;
            e.fe = lw || s.pcsrc;
            e.fd = s.pcsrc;
        end
        return e;
    endfunction

    task automatic advance();
        if (prev_s.rst) begin
            m_wait = 0; m_cnt = 0; m_err = 0; m_sc = 0; m_fc = 0;
        end else begin
            if (prev_e.sf || prev_e.sd || prev_e.se || prev_e.sm) m_sc = m_sc + 1;
            if (prev_e.fd || prev_e.fe) m_fc = m_fc + 1;
            if (m_wait) begin
                m_cnt = m_cnt + 1;
                if (m_cnt >= T) m_err = 1;
                if (prev_s.mrdy) begin
                    m_wait = 0;
                    m_cnt  = 0;
                end
            end else if (prev_s.macc && !prev_s.mrdy) begin
                m_wait = 1;
            end
        end
    endtask

    task automatic apply(stim_t s);
        rst = s.rst; Rs1D = s.rs1d; Rs2D = s.rs2d; Rs1E = s.rs1e; Rs2E = s.rs2e;
        RdE = s.rde; RdM = s.rdm; RdW = s.rdw; RegWriteM = s.rwm; RegWriteW = s.rww;
        LoadE = s.loade; PCSrcE = s.pcsrc; MemAccessM = s.macc; MemReadyM = s.mrdy;
    endtask

    task automatic step(stim_t s);
        exp_t e;
        @(posedge clk);
        #1;
        advance();
        apply(s);
        e = predict(s);
        q.push_back(e);
        prev_s = s;
        prev_e = e;
    endtask

    task automatic chk(string n, bit [31:0] act, bit [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", n, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            m_e = q.pop_front();
            chk("ForwardAE", 32'(ForwardAE), 32'(m_e.fa));
            chk("ForwardBE", 32'(ForwardBE), 32'(m_e.fb));
            chk("StallF",    32'(StallF),    32'(m_e.sf));
            chk("StallD",    32'(StallD),    32'(m_e.sd));
            chk("StallE",    32'(StallE),    32'(m_e.se));
            chk("StallM",    32'(StallM),    32'(m_e.sm));
            chk("FlushD",    32'(FlushD),    32'(m_e.fd));
            chk("FlushE",    32'(FlushE),    32'(m_e.fe));
            chk("FlushW",    32'(FlushW),    32'(m_e.fw));
            chk("MemReqM",   32'(MemReqM),   32'(m_e.req));
            chk("MemErr",    32'(MemErr),    32'(m_e.err));
            chk("StallCnt",  StallCnt,       m_e.sc);
            chk("FlushCnt",  FlushCnt,       m_e.fc);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        stim_t s;
        s = idle();
        s.rst = 1;
        prev_s = s;
        prev_e = '{default: '0};
        apply(s);

        step(s); step(s);

        // forwarding: M beats W, then W alone, then x0 never forwards
        s = idle(); s.rdm = 5; s.rwm = 1; s.rdw = 5; s.rww = 1; s.rs1e = 5;
        step(s);
        s.rwm = 0; step(s);
        s.rdm = 0; s.rdw = 0; s.rwm = 1; step(s);

        // load-use, then RdE = x0
        s = idle(); s.loade = 1; s.rde = 7; s.rs2d = 7; step(s);
        s.rde = 0; s.rs2d = 0; step(s);

        // branch flush for one cycle
        s = idle(); s.pcsrc = 1; step(s);
        s = idle(); step(s);

        // three wait cycles then ready
        s = idle(); s.macc = 1;
        repeat (3) step(s);
        s.mrdy = 1; step(s);
        s = idle(); step(s);

        // memStall hides a pending branch until release
        s = idle(); s.macc = 1; s.pcsrc = 1;
        repeat (2) step(s);
        s.mrdy = 1; step(s);
        s = idle(); step(s);

        // back-to-back accesses
        s = idle(); s.macc = 1; step(s);
        s.mrdy = 1; step(s);
        s.mrdy = 0; step(s);
        s.mrdy = 1; step(s);

        // timeout, then reset mid-wait
        s = idle(); s.macc = 1;
        repeat (6) step(s);
        s.rst = 1; step(s);
        s = idle(); step(s); step(s);

        repeat (3000) begin
            s.rst   = ($urandom_range(0, 63) == 0);
            s.rs1d  = 5'($urandom_range(0, 3));
            s.rs2d  = 5'($urandom_range(0, 3));
            s.rs1e  = 5'($urandom_range(0, 3));
            s.rs2e  = 5'($urandom_range(0, 3));
            s.rde   = 5'($urandom_range(0, 3));
            s.rdm   = 5'($urandom_range(0, 3));
            s.rdw   = 5'($urandom_range(0, 3));
            s.rwm   = 1'($urandom_range(0, 1));
            s.rww   = 1'($urandom_range(0, 1));
            s.loade = 1'($urandom_range(0, 1));
            s.pcsrc = ($urandom_range(0, 3) == 0);
            s.macc  = ($urandom_range(0, 9) < 4);
            s.mrdy  = 1'($urandom_range(0, 1));
            step(s);
        end

        @(negedge clk);
        #1;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
